audio_filt_sched: RTL and testbench

- Sample-rate scheduler that time-shares one biquad/IIR multiply-accumulate engine across the audio filter channels: PSG, FM L, FM R, mix L, mix R.
- On each filter clock-enable tick, it walks the enabled channels in ascending index order.
- For each channel it issues a one-cycle start to the shared MAC, waits for done, and flags commit of the result.
- It sits between the CEGen filter tick and the shared IIR datapath, and replaces per-channel free-running filter instances.

---
 rtl/audio_sched_pkg.sv | 22 ++
 rtl/audio_filt_sched_if.sv | 13 +
 rtl/audio_first_set.sv | 22 ++
 rtl/audio_filt_sched.sv | 122 ++++++++++++
 tb/tb_audio_filt_sched.sv | 381 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_sched_pkg.sv
// rtl/audio_sched_pkg.sv - shared types and constants for the filter scheduler
package audio_sched_pkg;

  // Width of a channel index on the MAC bus and the commit port
  localparam int CH_W = 3;

  // Filter channel indices, in scheduling priority order
  localparam int CH_PSG   = 0;
  localparam int CH_FM_L  = 1;
  localparam int CH_FM_R  = 2;
  localparam int CH_MIX_L = 3;
  localparam int CH_MIX_R = 4;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    NEXT,
    DONE
  } state_t;

endpackage

// File: rtl/audio_filt_sched_if.sv
// rtl/audio_filt_sched_if.sv - start/done handshake to the shared IIR MAC
interface audio_filt_sched_if;
  import audio_sched_pkg::*;

  logic            mac_start;
  logic [CH_W-1:0] mac_ch;
  logic            mac_done;

  // Scheduler side drives start and channel, MAC answers with done
  modport master (output mac_start, output mac_ch, input mac_done);
  modport slave  (input mac_start, input mac_ch, output mac_done);

endinterface

// File: rtl/audio_first_set.sv
// rtl/audio_first_set.sv - combinational lowest-set-bit encoder
module audio_first_set
  import audio_sched_pkg::*;
#(
  parameter int W  = 5,
  parameter int IW = CH_W
) (
  input  logic [W-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // Scan from the top down so the lowest set bit is the last one to win
  always_comb begin
    idx   = '0;
    valid = |vec;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/audio_filt_sched.sv
// rtl/audio_filt_sched.sv - time-shares one IIR MAC across the audio filter channels
module audio_filt_sched
  import audio_sched_pkg::*;
#(
  parameter int NCH     = 5,
  parameter int TIMEOUT = 63
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  tick,
  input  logic [NCH-1:0]        ch_mask,
  audio_filt_sched_if.master    mac,
  output logic                  commit,
  output logic [CH_W-1:0]       commit_ch,
  output logic                  frame_done,
  output logic                  busy,
  output logic                  overrun,
  output logic                  timeout_err,
  input  logic                  clr_status
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t           state;
  logic [NCH-1:0]   pend;
  logic [CNT_W-1:0] wait_cnt;
  logic [CH_W-1:0]  nxt_idx;
  logic             nxt_vld;
  logic             to_hit;
  logic             tick_busy;

  audio_first_set #(
    .W  (NCH),
    .IW (CH_W)
  ) u_first_set (
    .vec   (pend),
    .idx   (nxt_idx),
    .valid (nxt_vld)
  );

  // Last permitted wait cycle with no answer; a done in that same cycle takes priority
  assign to_hit    = (state == WAIT) && !mac.mac_done && (wait_cnt == CNT_W'(TIMEOUT - 1));
  // A qualified tick that lands while a frame is still running is lost
  assign tick_busy = tick && enable && (state != IDLE);

  // Frame sequencer: walk pending channels lowest first, one MAC job at a time
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      pend          <= '0;
      wait_cnt      <= '0;
      mac.mac_start <= 1'b0;
      mac.mac_ch    <= '0;
      commit        <= 1'b0;
      commit_ch     <= '0;
      frame_done    <= 1'b0;
      busy          <= 1'b0;
    end else begin
      mac.mac_start <= 1'b0;
      commit        <= 1'b0;
      frame_done    <= 1'b0;
      case (state)
        IDLE: begin
          if (tick && enable) begin
            pend  <= ch_mask;
            busy  <= 1'b1;
            state <= NEXT;
          end
        end
        NEXT: begin
          if (!nxt_vld) begin
            frame_done <= 1'b1;
            state      <= DONE;
          end else begin
            mac.mac_ch    <= nxt_idx;
            pend          <= pend & (pend - NCH'(1));
            wait_cnt      <= '0;
            mac.mac_start <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (mac.mac_done) begin
            commit    <= 1'b1;
            commit_ch <= mac.mac_ch;
            state     <= NEXT;
          end else if (to_hit) begin
            state <= NEXT;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Sticky overrun flag; a new overrun beats a simultaneous clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) overrun <= 1'b0;
    else if (tick_busy) overrun <= 1'b1;
    else if (clr_status) overrun <= 1'b0;
  end

  // Sticky timeout flag; a new timeout beats a simultaneous clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) timeout_err <= 1'b0;
    else if (to_hit) timeout_err <= 1'b1;
    else if (clr_status) timeout_err <= 1'b0;
  end

endmodule

// File: tb/tb_audio_filt_sched.sv
// tb/tb_audio_filt_sched.sv - randomized self-checking bench for audio_filt_sched
module tb_audio_filt_sched;
  import audio_sched_pkg::*;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            enable = 1'b0;
  logic            tick = 1'b0;
  logic [4:0]      ch_mask = '0;
  logic            clr_status = 1'b0;
  logic            commit;
  logic [CH_W-1:0] commit_ch;
  logic            frame_done;
  logic            busy;
  logic            overrun;
  logic            timeout_err;

  audio_filt_sched_if bus();

  audio_filt_sched #(.NCH(5), .TIMEOUT(63)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .tick        (tick),
    .ch_mask     (ch_mask),
    .mac         (bus),
    .commit      (commit),
    .commit_ch   (commit_ch),
    .frame_done  (frame_done),
    .busy        (busy),
    .overrun     (overrun),
    .timeout_err (timeout_err),
    .clr_status  (clr_status)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Per-channel MAC answer delay in cycles after the start; 0 means never answer
  int dly [8];
  int done_at = -1;
  int extra_done_at = -1;

  int st_cyc[$], st_ch[$], cm_cyc[$], cm_ch[$], fd_cyc[$];
  int e_st_cyc[$], e_st_ch[$], e_cm_cyc[$], e_cm_ch[$];
  int e_fd;
  bit e_to;

  // Observe the DUT mid-cycle and schedule the MAC reply for each start
  initial begin
    forever begin
      @(negedge clk);
      if (bus.mac_start) begin
        st_cyc.push_back(cyc);
        st_ch.push_back(int'(bus.mac_ch));
        done_at = (dly[bus.mac_ch] != 0) ? cyc + dly[bus.mac_ch] : -1;
      end
      if (commit) begin
        cm_cyc.push_back(cyc);
        cm_ch.push_back(int'(commit_ch));
      end
      if (frame_done) fd_cyc.push_back(cyc);
    end
  end

  // MAC responder
  initial begin
    bus.mac_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.mac_done = (cyc == done_at) || (cyc == extra_done_at);
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_obs();
    st_cyc.delete(); st_ch.delete(); cm_cyc.delete(); cm_ch.delete(); fd_cyc.delete();
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    step(1);
    clr_status = 1'b1;
    step(1);
    clr_status = 1'b0;
  endtask

  task automatic start_frame(input logic [4:0] mask, output int t);
    step(1);
    ch_mask = mask;
    enable  = 1'b1;
    tick    = 1'b1;
    t       = cyc;
    step(1);
    tick    = 1'b0;
    ch_mask = 5'($urandom);
  endtask

  task automatic wait_frame(input int limit);
    int n = 0;
    while (fd_cyc.size() == 0 && n < limit) begin
      step(1);
      n++;
    end
    step(3);
  endtask

  // Reference schedule: each masked channel in ascending order starts two cycles
  // after the previous decision point; an answer d cycles after the start commits
  // one cycle later and the next start follows one cycle after that; no answer
  // within 63 wait cycles costs 63 wait cycles plus one bookkeeping cycle.
  task automatic model_frame(input logic [4:0] mask, input int t);
    int cur;
    e_st_cyc.delete(); e_st_ch.delete(); e_cm_cyc.delete(); e_cm_ch.delete();
    e_to = 1'b0;
    cur = t + 2;
    for (int c = 0; c < 5; c++) begin
      if (mask[c]) begin
        e_st_cyc.push_back(cur);
        e_st_ch.push_back(c);
        if (dly[c] >= 1 && dly[c] <= 63) begin
          e_cm_cyc.push_back(cur + dly[c] + 1);
          e_cm_ch.push_back(c);
          cur = cur + dly[c] + 2;
        end else begin
          e_to = 1'b1;
          cur = cur + 65;
        end
      end
    end
    e_fd = cur;
  endtask

  function automatic int pick_delay();
    int r = $urandom_range(0, 9);
    case (r)
      0:       return 0;
      1:       return 63;
      2:       return 64;
      default: return $urandom_range(1, 6);
    endcase
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.mac_start, bus.mac_ch, commit, commit_ch, frame_done, busy, overrun, timeout_err} !== '0) begin
      errors++;
      $display("FAIL reset_hold got %b exp 0", {bus.mac_start, bus.mac_ch, commit, commit_ch, frame_done, busy, overrun, timeout_err});
    end
    reset_n = 1'b1;
    step(2);
    checks++;
    if ({bus.mac_start, commit, frame_done, busy, overrun, timeout_err} !== '0) begin
      errors++;
      $display("FAIL reset_release got %b exp 0", {bus.mac_start, commit, frame_done, busy, overrun, timeout_err});
    end
  endtask

  task automatic test_enable_off();
    clear_obs();
    enable = 1'b0;
    step(1);
    ch_mask = 5'b11111;
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    step(8);
    checks++;
    if (st_cyc.size() != 0 || fd_cyc.size() != 0) begin
      errors++;
      $display("FAIL enable_off_events got starts %0d frames %0d exp 0 0", st_cyc.size(), fd_cyc.size());
    end
    checks++;
    if (overrun !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL enable_off_flags got overrun %b busy %b exp 0 0", overrun, busy);
    end
    enable = 1'b1;
  endtask

  task automatic test_idle_done();
    clear_obs();
    extra_done_at = cyc + 2;
    step(6);
    extra_done_at = -1;
    checks++;
    if (cm_cyc.size() != 0 || st_cyc.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_done got commits %0d starts %0d busy %b exp 0 0 0", cm_cyc.size(), st_cyc.size(), busy);
    end
  endtask

  task automatic test_frames();
    logic [4:0] mask;
    int t;
    for (int k = 0; k < 16; k++) begin
      for (int c = 0; c < 8; c++) dly[c] = pick_delay();
      case (k)
        0: begin mask = 5'b11111; for (int c = 0; c < 5; c++) dly[c] = 4; end
        1: begin mask = 5'b10100; dly[2] = $urandom_range(1, 6); dly[4] = $urandom_range(1, 6); end
        2: mask = 5'b00000;
        3: begin mask = 5'b00011; dly[0] = 3; dly[1] = 0; end
        4: begin mask = 5'b00100; dly[2] = 63; end
        5: begin mask = 5'b01001; dly[0] = 65; dly[3] = 2; end
        6: begin mask = 5'b00010; dly[1] = 64; end
        default: mask = 5'($urandom);
      endcase
      pulse_clr();
      clear_obs();
      start_frame(mask, t);
      if (k >= 7 && $urandom_range(0, 1) == 1) enable = 1'b0;
      model_frame(mask, t);
      wait_frame(e_fd - t + 10);
      enable = 1'b1;

      checks++;
      if (fd_cyc.size() != 1) begin
        errors++;
        $display("FAIL frame%0d_done_count got %0d exp 1", k, fd_cyc.size());
      end else begin
        checks++;
        if (fd_cyc[0] != e_fd) begin
          errors++;
          $display("FAIL frame%0d_done_cycle got %0d exp %0d", k, fd_cyc[0] - t, e_fd - t);
        end
      end
      checks++;
      if (st_cyc.size() != e_st_cyc.size()) begin
        errors++;
        $display("FAIL frame%0d_start_count got %0d exp %0d", k, st_cyc.size(), e_st_cyc.size());
      end
      for (int i = 0; i < st_cyc.size() && i < e_st_cyc.size(); i++) begin
        checks++;
        if (st_ch[i] != e_st_ch[i] || st_cyc[i] != e_st_cyc[i]) begin
          errors++;
          $display("FAIL frame%0d_start%0d got ch %0d at %0d exp ch %0d at %0d", k, i, st_ch[i], st_cyc[i] - t, e_st_ch[i], e_st_cyc[i] - t);
        end
      end
      checks++;
      if (cm_cyc.size() != e_cm_cyc.size()) begin
        errors++;
        $display("FAIL frame%0d_commit_count got %0d exp %0d", k, cm_cyc.size(), e_cm_cyc.size());
      end
      for (int i = 0; i < cm_cyc.size() && i < e_cm_cyc.size(); i++) begin
        checks++;
        if (cm_ch[i] != e_cm_ch[i] || cm_cyc[i] != e_cm_cyc[i]) begin
          errors++;
          $display("FAIL frame%0d_commit%0d got ch %0d at %0d exp ch %0d at %0d", k, i, cm_ch[i], cm_cyc[i] - t, e_cm_ch[i], e_cm_cyc[i] - t);
        end
      end
      checks++;
      if (timeout_err !== e_to) begin
        errors++;
        $display("FAIL frame%0d_timeout_err got %b exp %b", k, timeout_err, e_to);
      end
      checks++;
      if (overrun !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL frame%0d_idle_flags got overrun %b busy %b exp 0 0", k, overrun, busy);
      end
      if (k == 3) begin
        pulse_clr();
        checks++;
        if (timeout_err !== 1'b0) begin
          errors++;
          $display("FAIL clr_timeout got %b exp 0", timeout_err);
        end
      end
    end
  endtask

  task automatic test_overrun();
    int t;
    int n = 0;
    for (int c = 0; c < 8; c++) dly[c] = 4;
    pulse_clr();
    clear_obs();
    start_frame(5'b11111, t);
    model_frame(5'b11111, t);
    while (st_ch.size() < 3 && n < 100) begin
      step(1);
      n++;
    end
    step(1);
    tick = 1'b1;
    clr_status = 1'b1;
    step(1);
    tick = 1'b0;
    clr_status = 1'b0;
    wait_frame(e_fd - t + 10);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set got %b exp 1", overrun);
    end
    checks++;
    if (fd_cyc.size() != 1 || cm_cyc.size() != 5) begin
      errors++;
      $display("FAIL overrun_frame got frames %0d commits %0d exp 1 5", fd_cyc.size(), cm_cyc.size());
    end
    for (int i = 0; i < cm_cyc.size() && i < 5; i++) begin
      checks++;
      if (cm_ch[i] != i || cm_cyc[i] != e_cm_cyc[i]) begin
        errors++;
        $display("FAIL overrun_commit%0d got ch %0d at %0d exp ch %0d at %0d", i, cm_ch[i], cm_cyc[i] - t, i, e_cm_cyc[i] - t);
      end
    end
    pulse_clr();
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL clr_overrun got %b exp 0", overrun);
    end
  endtask

  task automatic test_reset_mid();
    int t;
    int n = 0;
    for (int c = 0; c < 8; c++) dly[c] = 10;
    clear_obs();
    start_frame(5'b11111, t);
    while (st_ch.size() < 2 && n < 100) begin
      step(1);
      n++;
    end
    checks++;
    if (st_ch.size() < 2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_setup got starts %0d busy %b exp 2 1", st_ch.size(), busy);
    end
    step(1);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.mac_start, bus.mac_ch, commit, commit_ch, frame_done, busy, overrun, timeout_err} !== '0) begin
      errors++;
      $display("FAIL reset_async got %b exp 0", {bus.mac_start, bus.mac_ch, commit, commit_ch, frame_done, busy, overrun, timeout_err});
    end
    step(2);
    reset_n = 1'b1;
    clear_obs();
    step(100);
    checks++;
    if (st_cyc.size() != 0 || cm_cyc.size() != 0 || fd_cyc.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_quiet got starts %0d commits %0d frames %0d busy %b exp 0 0 0 0", st_cyc.size(), cm_cyc.size(), fd_cyc.size(), busy);
    end
  endtask

  initial begin
    for (int c = 0; c < 8; c++) dly[c] = 0;
    test_reset();
    test_enable_off();
    test_idle_done();
    test_frames();
    test_overrun();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
